jk_flipflop: RTL and testbench

// - Clocked JK memory element with four controllable states per bit:

---
 rtl/jk_flipflop.sv | 44 ++++
 tb/tb_jk_flipflop.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/jk_flipflop.sv
// rtl/jk_flipflop.sv - per-bit JK flip-flop with complementary outputs
module jk_flipflop #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar
);

   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] q_next;

   // Per-bit next state; any control pattern other than a clean 00/01/10/11
   // (e.g. X or Z in simulation) falls into the default and holds the bit.
   always_comb begin
      q_next = q_reg;
      for (int i = 0; i < WIDTH; i++) begin
         case ({j[i], k[i]})
            2'b00:   q_next[i] = q_reg[i];
            2'b01:   q_next[i] = 1'b0;
            2'b10:   q_next[i] = 1'b1;
            2'b11:   q_next[i] = ~q_reg[i];
            default: q_next[i] = q_reg[i];
         endcase
      end
   end

   // Single state register; the async reset overrides any clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_reg <= '0;
      end else begin
         q_reg <= q_next;
      end
   end

   // Both outputs come from the same register, so they can never be equal.
   assign q    = q_reg;
   assign qbar = ~q_reg;

endmodule

// File: tb/tb_jk_flipflop.sv
// tb/tb_jk_flipflop.sv - self-checking bench for jk_flipflop
module tb_jk_flipflop;

   logic       clk;
   logic       rst_n;
   logic       j1, k1;
   logic       q1, qbar1;
   logic [3:0] j4, k4;
   logic [3:0] q4, qbar4;

   int tests;
   int failures;

   typedef struct {
      logic j;
      logic k;
      logic exp_q;
   } vec_t;

   vec_t vecs [8];

   jk_flipflop #(.WIDTH(1)) u1 (
      .clk  (clk),
      .rst_n(rst_n),
      .j    (j1),
      .k    (k1),
      .q    (q1),
      .qbar (qbar1)
   );

   jk_flipflop #(.WIDTH(4)) u4 (
      .clk  (clk),
      .rst_n(rst_n),
      .j    (j4),
      .k    (k4),
      .q    (q4),
      .qbar (qbar4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      logic [3:0] m4;
      logic       m1;

      tests    = 0;
      failures = 0;

      // truth table from q=0, then four toggles
      vecs[0] = '{1'b1, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 1'b1};
      vecs[7] = '{1'b1, 1'b1, 1'b0};

      // reset held with toggle requested
      rst_n = 1'b0;
      j1 = 1'b1;  k1 = 1'b1;
      j4 = 4'hf;  k4 = 4'hf;
      #1;
      check("reset_q_t0", {3'b0, q1}, 4'h0);
      check("reset_qbar_t0", {3'b0, qbar1}, 4'h1);
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         #1;
         check("reset_q", {3'b0, q1}, 4'h0);
         check("reset_qbar", {3'b0, qbar1}, 4'h1);
         check("reset_q4", q4, 4'h0);
         check("reset_qbar4", qbar4, 4'hf);
      end

      // release and walk the vector table
      @(negedge clk);
      rst_n = 1'b1;
      j4 = 4'h0;  k4 = 4'h0;
      for (int v = 0; v < 8; v++) begin
         j1 = vecs[v].j;
         k1 = vecs[v].k;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_q", v), {3'b0, q1}, {3'b0, vecs[v].exp_q});
         check($sformatf("vec%0d_qbar", v), {3'b0, qbar1}, {3'b0, ~vecs[v].exp_q});
         @(negedge clk);
      end
      check("hold_q4", q4, 4'h0);

      // async reset between edges while q=1
      j1 = 1'b1;  k1 = 1'b1;
      @(posedge clk);
      #1;
      check("pre_async_q", {3'b0, q1}, 4'h1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_q", {3'b0, q1}, 4'h0);
      check("async_qbar", {3'b0, qbar1}, 4'h1);
      @(posedge clk);
      #1;
      check("async_hold_q", {3'b0, q1}, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("release_toggle_q", {3'b0, q1}, 4'h1);
      check("release_toggle_qbar", {3'b0, qbar1}, 4'h0);

      // WIDTH=4 mixed operation from q=0011
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      j1 = 1'b0;  k1 = 1'b0;
      j4 = 4'b0011;  k4 = 4'b0000;
      @(posedge clk);
      #1;
      check("w4_setup", q4, 4'b0011);
      @(negedge clk);
      j4 = 4'b1010;  k4 = 4'b0110;
      @(posedge clk);
      #1;
      check("w4_mixed_q", q4, 4'b1001);
      check("w4_mixed_qbar", qbar4, 4'b0110);

      // random scoreboard
      m1 = 1'b0;
      m4 = 4'b1001;
      @(negedge clk);
      m1 = q1 ^ q1;
      for (int c = 0; c < 200; c++) begin
         j1 = 1'($urandom_range(0, 1));
         k1 = 1'($urandom_range(0, 1));
         j4 = 4'($urandom_range(0, 15));
         k4 = 4'($urandom_range(0, 15));
         m1 = (j1 & ~m1) | (~k1 & m1);
         m4 = (j4 & ~m4) | (~k4 & m4);
         @(posedge clk);
         #1;
         check("rand_q1", {3'b0, q1}, {3'b0, m1});
         check("rand_qbar1", {3'b0, qbar1}, {3'b0, ~m1});
         check("rand_q4", q4, m4);
         check("rand_qbar4", qbar4, ~m4);
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
